gshare_branch_predictor: RTL and testbench

GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

---
 rtl/gshare_branch_predictor_if.sv | 38 +++
 rtl/gshare_branch_predictor.sv | 103 ++++++++++
 tb/tb_gshare_branch_predictor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup, decode-side BTB write and execute-side resolve signals
// shared between the pipeline (master) and the branch predictor (slave).
interface gshare_branch_predictor_if #(
   parameter int WORD_SIZE = 16,
   parameter int GHR_LEN   = 8
);
   logic [WORD_SIZE-1:0] pc_if;
   logic                 predict_en;

   logic                 upd_btb_valid;
   logic [WORD_SIZE-1:0] upd_btb_pc;
   logic [WORD_SIZE-1:0] upd_btb_target;

   logic                 resolve_valid;
   logic [WORD_SIZE-1:0] resolve_pc;
   logic                 resolve_taken;
   logic                 resolve_mispredict;
   logic [GHR_LEN-1:0]   resolve_ghr;

   logic                 pred_hit;
   logic                 pred_taken;
   logic [WORD_SIZE-1:0] pred_pc;
   logic [GHR_LEN-1:0]   pred_ghr;

   modport master (
      output pc_if, predict_en,
      output upd_btb_valid, upd_btb_pc, upd_btb_target,
      output resolve_valid, resolve_pc, resolve_taken, resolve_mispredict, resolve_ghr,
      input  pred_hit, pred_taken, pred_pc, pred_ghr
   );

   modport slave (
      input  pc_if, predict_en,
      input  upd_btb_valid, upd_btb_pc, upd_btb_target,
      input  resolve_valid, resolve_pc, resolve_taken, resolve_mispredict, resolve_ghr,
      output pred_hit, pred_taken, pred_pc, pred_ghr
   );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter table, indexed by PC (bimodal) or
// PC xor global history (gshare); speculative GHR repaired on mispredict.
module gshare_branch_predictor #(
   parameter int         WORD_SIZE    = 16,
   parameter int         BTB_IDX_SIZE = 8,
   parameter int         GHR_LEN      = 8,
   parameter int         MODE         = 2,
   parameter logic [1:0] COUNTER_INIT = 2'b01
) (
   input logic                      clk,
   input logic                      reset,
   gshare_branch_predictor_if.slave bp
);
   localparam int ENTRIES = 2 ** BTB_IDX_SIZE;
   localparam int TAG_W   = WORD_SIZE - BTB_IDX_SIZE;

   typedef logic [BTB_IDX_SIZE-1:0] idx_t;
   typedef logic [GHR_LEN-1:0]      ghr_t;

   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q    [ENTRIES];
   logic [TAG_W-1:0]     tag_d    [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [WORD_SIZE-1:0] target_d [ENTRIES];
   logic [1:0]           ctr_q    [ENTRIES];
   logic [1:0]           ctr_d    [ENTRIES];
   ghr_t                 ghr_q, ghr_d;

   idx_t             look_bidx, pred_idx, upd_bidx, res_bidx, res_idx;
   logic [TAG_W-1:0] look_tag, upd_tag;
   logic             hit, taken;

   assign look_bidx = bp.pc_if[BTB_IDX_SIZE-1:0];
   assign look_tag  = bp.pc_if[WORD_SIZE-1:BTB_IDX_SIZE];
   assign upd_bidx  = bp.upd_btb_pc[BTB_IDX_SIZE-1:0];
   assign upd_tag   = bp.upd_btb_pc[WORD_SIZE-1:BTB_IDX_SIZE];
   assign res_bidx  = bp.resolve_pc[BTB_IDX_SIZE-1:0];

   // Only gshare folds history into the counter index; the resolve side uses
   // the snapshot that travelled with the branch so it hits the same counter.
   assign pred_idx = (MODE == 2) ? (look_bidx ^ idx_t'(ghr_q))          : look_bidx;
   assign res_idx  = (MODE == 2) ? (res_bidx  ^ idx_t'(bp.resolve_ghr)) : res_bidx;

   always_comb begin
      hit   = valid_q[look_bidx] && (tag_q[look_bidx] == look_tag);
      taken = hit && ((MODE == 0) ? 1'b1 : ctr_q[pred_idx][1]);
   end

   assign bp.pred_hit   = hit;
   assign bp.pred_taken = taken;
   assign bp.pred_pc    = taken ? target_q[look_bidx] : bp.pc_if + WORD_SIZE'(1);
   assign bp.pred_ghr   = ghr_q;

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (bp.upd_btb_valid) begin
         valid_d[upd_bidx]  = 1'b1;
         tag_d[upd_bidx]    = upd_tag;
         target_d[upd_bidx] = bp.upd_btb_target;
      end
   end

   always_comb begin
      ctr_d = ctr_q;
      if ((MODE != 0) && bp.resolve_valid) begin
         if (bp.resolve_taken) begin
            if (ctr_q[res_idx] != 2'b11) ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
         end else begin
            if (ctr_q[res_idx] != 2'b00) ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
         end
      end
   end

   // A mispredict repair discards whatever speculative shift happens this cycle.
   always_comb begin
      ghr_d = ghr_q;
      if (bp.resolve_valid && bp.resolve_mispredict) begin
         ghr_d = ghr_t'({bp.resolve_ghr, bp.resolve_taken});
      end else if (bp.predict_en && hit) begin
         ghr_d = ghr_t'({ghr_q, taken});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         ghr_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= COUNTER_INIT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
         ghr_q    <= ghr_d;
      end
   end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Drives one stimulus stream into always-taken, bimodal and gshare instances
// and compares every output against an array-based reference model.
module tb_gshare_branch_predictor;
   localparam int N = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc_if, upd_btb_pc, upd_btb_target, resolve_pc;
   logic        predict_en, upd_btb_valid, resolve_valid, resolve_taken, resolve_mispredict;
   logic [7:0]  resolve_ghr;

   logic [2:0]  hit_o, taken_o;
   logic [15:0] pc_o  [3];
   logic [7:0]  ghr_o [3];

   int pass_count  = 0;
   int check_count = 0;

   bit m_valid [N];
   int m_tag   [N];
   int m_tgt   [N];
   int m_ctr   [3][N];
   int m_ghr   [3];

   int idx_pool [8] = '{'h12, 'h17, 'h05, 'h40, 'h80, 'h81, 'hFF, 'h00};

   always #5 clk = ~clk;

   gshare_branch_predictor_if #(.WORD_SIZE(16), .GHR_LEN(8)) bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : gen_mode
      assign bus[g].pc_if              = pc_if;
      assign bus[g].predict_en         = predict_en;
      assign bus[g].upd_btb_valid      = upd_btb_valid;
      assign bus[g].upd_btb_pc         = upd_btb_pc;
      assign bus[g].upd_btb_target     = upd_btb_target;
      assign bus[g].resolve_valid      = resolve_valid;
      assign bus[g].resolve_pc         = resolve_pc;
      assign bus[g].resolve_taken      = resolve_taken;
      assign bus[g].resolve_mispredict = resolve_mispredict;
      assign bus[g].resolve_ghr        = resolve_ghr;
      assign hit_o[g]   = bus[g].pred_hit;
      assign taken_o[g] = bus[g].pred_taken;
      assign pc_o[g]    = bus[g].pred_pc;
      assign ghr_o[g]   = bus[g].pred_ghr;

      gshare_branch_predictor #(
         .WORD_SIZE(16), .BTB_IDX_SIZE(8), .GHR_LEN(8), .MODE(g), .COUNTER_INIT(2'b01)
      ) dut (
         .clk(clk),
         .reset(reset),
         .bp(bus[g])
      );
   end

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         for (int m = 0; m < 3; m++) m_ctr[m][i] = 1;
      end
      for (int m = 0; m < 3; m++) m_ghr[m] = 0;
   endtask

   function automatic int counter_index(int m, int pc, int ghr);
      return (m == 2) ? ((pc % N) ^ ghr) : (pc % N);
   endfunction

   task automatic model_predict(input int m, output bit hit, output bit taken, output int npc);
      int p = int'(pc_if);
      int b = p % N;
      hit   = m_valid[b] && (m_tag[b] == p / N);
      taken = hit && (m == 0 || m_ctr[m][counter_index(m, p, m_ghr[m])] >= 2);
      npc   = taken ? m_tgt[b] : (p + 1) % 65536;
   endtask

   // Applied just after a clock edge; inputs are still the pre-edge values.
   task automatic model_edge();
      bit hit, taken;
      int npc, ci;
      for (int m = 0; m < 3; m++) begin
         model_predict(m, hit, taken, npc);
         if (m != 0 && resolve_valid) begin
            ci = counter_index(m, int'(resolve_pc), int'(resolve_ghr));
            if (resolve_taken) m_ctr[m][ci] = (m_ctr[m][ci] < 3) ? m_ctr[m][ci] + 1 : 3;
            else               m_ctr[m][ci] = (m_ctr[m][ci] > 0) ? m_ctr[m][ci] - 1 : 0;
         end
         if (resolve_valid && resolve_mispredict)
            m_ghr[m] = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % 256;
         else if (predict_en && hit)
            m_ghr[m] = (m_ghr[m] * 2 + int'(taken)) % 256;
      end
      if (upd_btb_valid) begin
         m_valid[int'(upd_btb_pc) % N] = 1'b1;
         m_tag[int'(upd_btb_pc) % N]   = int'(upd_btb_pc) / N;
         m_tgt[int'(upd_btb_pc) % N]   = int'(upd_btb_target);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic checkOutput();
      bit hit, taken;
      int npc;
      #1;
      for (int m = 0; m < 3; m++) begin
         model_predict(m, hit, taken, npc);
         check($sformatf("m%0d_hit pc=%0h", m, pc_if),   hit_o[m],   hit);
         check($sformatf("m%0d_taken pc=%0h", m, pc_if), taken_o[m], taken);
         check($sformatf("m%0d_pc pc=%0h", m, pc_if),    pc_o[m],    npc);
         check($sformatf("m%0d_ghr pc=%0h", m, pc_if),   ghr_o[m],   m_ghr[m]);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] pc, input logic pe,
                                input logic uv, input logic [15:0] upc, input logic [15:0] utgt,
                                input logic rv, input logic [15:0] rpc, input logic rt,
                                input logic rm, input logic [7:0] rg);
      pc_if = pc;              predict_en = pe;
      upd_btb_valid = uv;      upd_btb_pc = upc;        upd_btb_target = utgt;
      resolve_valid = rv;      resolve_pc = rpc;        resolve_taken = rt;
      resolve_mispredict = rm; resolve_ghr = rg;
   endtask

   task automatic idle(input logic [15:0] pc);
      applyStimulus(pc, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0);
   endtask

   task automatic run_cycle();
      checkOutput();
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge();
      @(negedge clk);
   endtask

   initial begin
      // Strobes held active through reset must leave no trace.
      reset = 1'b1;
      applyStimulus(16'h0012, 1'b1, 1'b1, 16'h0012, 16'h0040, 1'b1, 16'h0012, 1'b1, 1'b1, 8'h33);
      model_reset();
      repeat (2) run_cycle();
      reset = 1'b0;

      idle(16'h0012); run_cycle();
      idle(16'hFFFF); run_cycle();

      applyStimulus(16'h0012, 1'b0, 1'b1, 16'h0012, 16'h0040, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0);
      run_cycle();
      applyStimulus(16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012, 1'b1, 1'b0, 8'h0);
      repeat (2) run_cycle();
      applyStimulus(16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012, 1'b0, 1'b0, 8'h0);
      run_cycle();
      idle(16'h0012); run_cycle();
      check("req031_m1_taken", taken_o[1], 1'b1);

      applyStimulus(16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012, 1'b1, 1'b0, 8'h0);
      repeat (5) run_cycle();
      applyStimulus(16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012, 1'b0, 1'b0, 8'h0);
      run_cycle();
      idle(16'h0012); run_cycle();
      applyStimulus(16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0012, 1'b0, 1'b0, 8'h0);
      repeat (3) run_cycle();
      idle(16'h0012); run_cycle();

      applyStimulus(16'h0012, 1'b0, 1'b1, 16'h0112, 16'h0077, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0);
      run_cycle();
      idle(16'h0012); run_cycle();
      idle(16'h0112); run_cycle();

      applyStimulus(16'h0112, 1'b0, 1'b1, 16'h0212, 16'h0099, 1'b1, 16'h0212, 1'b1, 1'b0, 8'h0);
      run_cycle();
      idle(16'h0212); run_cycle();

      // Train gshare counter 0x12^0x05, then force GHR to 0x05 via a repair.
      applyStimulus(16'h0212, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0017, 1'b1, 1'b0, 8'h0);
      repeat (2) run_cycle();
      applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b1, 8'h02);
      run_cycle();
      applyStimulus(16'h0212, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0212, 1'b0, 1'b1, 8'h80);
      #1;
      check("req034_m2_ghr_before", ghr_o[2], 8'h05);
      check("req034_m2_taken", taken_o[2], 1'b1);
      run_cycle();
      idle(16'h0212); run_cycle();
      check("req034_m2_ghr_after", ghr_o[2], 8'h00);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(16'($urandom_range(0, 3) * 256 + idx_pool[$urandom_range(0, 7)]),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 9) < 3),
                       16'($urandom_range(0, 3) * 256 + idx_pool[$urandom_range(0, 7)]),
                       16'($urandom),
                       1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 3) * 256 + idx_pool[$urandom_range(0, 7)]),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0),
                       8'($urandom));
         run_cycle();
      end

      applyStimulus(16'h0012, 1'b1, 1'b1, 16'h0012, 16'h0055, 1'b1, 16'h0012, 1'b1, 1'b1, 8'hA5);
      #2;
      reset = 1'b1;
      model_reset();
      checkOutput();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(16'h0012);
      checkOutput();

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
